pi1_rgbled: RTL

PI1_RGBLED -- requirements
Module: pi1_rgbled

---
 rtl/pi1_rgbled.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pi1_rgbled.sv
// PI1 slave driving a three-channel PWM RGB LED with frame-synchronous
// duty updates and a frame-counted blink generator.
//
// Blink state machine (advances only at frame boundaries):
//   state  | meaning
//   ST_ON  | PWM drives the LEDs; counts ON frames
//   ST_OFF | LEDs forced off; counts OFF frames
module pi1_rgbled #(
  parameter int ARCHBITSZ = 32,
  parameter int ADDRBITSZ = ARCHBITSZ - 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             pi1_op_i,
  input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
  output logic                   pi1_rdy_o,
  output logic [ADDRBITSZ-1:0]   pi1_mapsz_o,
  output logic                   led_red_n,
  output logic                   led_green_n,
  output logic                   led_blue_n
);

  typedef enum logic {ST_ON = 1'b0, ST_OFF = 1'b1} blink_st_t;

  logic [23:0]          r_duty;
  logic [15:0]          r_presc;
  logic [15:0]          r_blink_on;
  logic [15:0]          r_blink_off;
  logic [7:0]           r_sh_red, r_sh_green, r_sh_blue;
  logic [15:0]          r_prescnt;
  logic [7:0]           r_phase;
  blink_st_t            r_blink_st;
  logic [15:0]          r_blink_cnt;
  logic [ARCHBITSZ-1:0] r_data_o;
  logic                 r_rdy;
  logic                 r_led_red, r_led_green, r_led_blue;

  logic                 w_wr, w_rd;
  logic [1:0]           w_addr;
  logic                 w_wr_duty, w_wr_presc, w_wr_blink, w_blink_touch;
  logic                 w_tick, w_frame;
  logic [15:0]          w_cnt_inc;
  logic [ARCHBITSZ-1:0] w_rdata;
  logic                 w_unused;

  // op bit 0 = write, bit 1 = read (RW sets both)
  assign w_wr          = pi1_op_i[0];
  assign w_rd          = pi1_op_i[1];
  assign w_addr        = pi1_addr_i[1:0];
  assign w_wr_duty     = w_wr && (w_addr == 2'd0);
  assign w_wr_presc    = w_wr && (w_addr == 2'd1);
  assign w_wr_blink    = w_wr && (w_addr == 2'd2);
  assign w_blink_touch = w_wr_blink && (|pi1_sel_i);
  assign w_tick        = (r_prescnt == 16'd0);
  assign w_frame       = w_tick && (r_phase == 8'hFF);
  assign w_cnt_inc     = r_blink_cnt + 16'd1;
  assign w_unused      = ^pi1_addr_i[ADDRBITSZ-1:2];

  assign pi1_mapsz_o = ADDRBITSZ'(4);
  assign pi1_data_o  = r_data_o;
  assign pi1_rdy_o   = r_rdy;
  assign led_red_n   = r_led_red;
  assign led_green_n = r_led_green;
  assign led_blue_n  = r_led_blue;

  // read mux over the current (pre-write) register contents
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      2'd0: w_rdata[23:0] = r_duty;
      2'd1: w_rdata[15:0] = r_presc;
      2'd2: w_rdata[31:0] = {r_blink_off, r_blink_on};
      default: w_rdata[31:0] = {r_blink_cnt, 7'd0, (r_blink_st == ST_ON), r_phase};
    endcase
  end

  // configuration registers with byte-enable writes
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_duty      <= '0;
      r_presc     <= '0;
      r_blink_on  <= '0;
      r_blink_off <= '0;
    end else begin
      if (w_wr_duty) begin
        if (pi1_sel_i[0]) r_duty[7:0]   <= pi1_data_i[7:0];
        if (pi1_sel_i[1]) r_duty[15:8]  <= pi1_data_i[15:8];
        if (pi1_sel_i[2]) r_duty[23:16] <= pi1_data_i[23:16];
      end
      if (w_wr_presc) begin
        if (pi1_sel_i[0]) r_presc[7:0]  <= pi1_data_i[7:0];
        if (pi1_sel_i[1]) r_presc[15:8] <= pi1_data_i[15:8];
      end
      if (w_wr_blink) begin
        if (pi1_sel_i[0]) r_blink_on[7:0]   <= pi1_data_i[7:0];
        if (pi1_sel_i[1]) r_blink_on[15:8]  <= pi1_data_i[15:8];
        if (pi1_sel_i[2]) r_blink_off[7:0]  <= pi1_data_i[23:16];
        if (pi1_sel_i[3]) r_blink_off[15:8] <= pi1_data_i[31:24];
      end
    end
  end

  // prescaler, phase counter and frame-boundary shadow capture of DUTY;
  // a PRESC write only lands on the next reload since the count is left alone
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_prescnt  <= '0;
      r_phase    <= '0;
      r_sh_red   <= '0;
      r_sh_green <= '0;
      r_sh_blue  <= '0;
    end else if (w_tick) begin
      r_prescnt <= r_presc;
      r_phase   <= r_phase + 8'd1;
      if (w_frame) begin
        r_sh_red   <= r_duty[7:0];
        r_sh_green <= r_duty[15:8];
        r_sh_blue  <= r_duty[23:16];
      end
    end else begin
      r_prescnt <= r_prescnt - 16'd1;
    end
  end

  // blink state machine and registered active-low LED drives
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_blink_st  <= ST_ON;
      r_blink_cnt <= '0;
      r_led_red   <= 1'b1;
      r_led_green <= 1'b1;
      r_led_blue  <= 1'b1;
    end else begin
      r_led_red   <= !((r_blink_st == ST_ON) && (r_phase < r_sh_red));
      r_led_green <= !((r_blink_st == ST_ON) && (r_phase < r_sh_green));
      r_led_blue  <= !((r_blink_st == ST_ON) && (r_phase < r_sh_blue));
      if (w_blink_touch) begin
        r_blink_st  <= ST_ON;
        r_blink_cnt <= '0;
      end else if (w_frame) begin
        case (r_blink_st)
          ST_ON: begin
            // ON=0 naturally matches after the 16-bit count wraps (65536 frames)
            if ((w_cnt_inc == r_blink_on) && (r_blink_off != 16'd0)) begin
              r_blink_st  <= ST_OFF;
              r_blink_cnt <= '0;
            end else begin
              r_blink_cnt <= w_cnt_inc;
            end
          end
          default: begin
            if (w_cnt_inc == r_blink_off) begin
              r_blink_st  <= ST_ON;
              r_blink_cnt <= '0;
            end else begin
              r_blink_cnt <= w_cnt_inc;
            end
          end
        endcase
      end
    end
  end

  // bus response: always ready out of reset, registered read data
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rdy    <= 1'b0;
      r_data_o <= '0;
    end else begin
      r_rdy <= 1'b1;
      if (w_rd) r_data_o <= w_rdata;
    end
  end

endmodule
